// File: rtl/jogo_defs.sv
// ============================================================================
// Module  : jogo_defs (package)
// Purpose : Shared definitions for the play-capture path. These are the FSM
//           state encodings, the play-code width and the one-hot check.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package jogo_defs;

  localparam int JOGADA_W = 8;

  typedef enum logic [2:0] {
    ESPERA = 3'd0,
    FILTRA = 3'd1,
    EMITE  = 3'd2,
    SEGURA = 3'd3,
    SOLTA  = 3'd4
  } estado_t;

  // True when exactly one bit of v is set
  function automatic logic is_onehot(input logic [JOGADA_W-1:0] v);
    return (v != '0) && ((v & (v - JOGADA_W'(1))) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/captura_jogada_if.sv
// ============================================================================
// Module  : captura_jogada_if
// Purpose : Bundles the button inputs, the control pulse and the play-code
//           outputs of captura_jogada. The master side drives buttons and
//           iniciar. The slave side is the capture block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface captura_jogada_if;
  import jogo_defs::*;

  logic                iniciar;
  logic [JOGADA_W-1:0] botoes;
  logic [JOGADA_W-1:0] jogada;
  logic                jogada_valida;
  logic                tem_jogada;
  logic                timeout;

  modport master (
    output iniciar, botoes,
    input  jogada, jogada_valida, tem_jogada, timeout
  );

  modport slave (
    input  iniciar, botoes,
    output jogada, jogada_valida, tem_jogada, timeout
  );
endinterface

`default_nettype wire

// File: rtl/sincronizador_2ff.sv
// ============================================================================
// Module  : sincronizador_2ff
// Purpose : Two-flop synchroniser for asynchronous level inputs. Both stages
//           clear on synchronous reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sincronizador_2ff #(
  parameter int WIDTH = 8
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back stages give metastability time to resolve
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/captura_jogada.sv
// ============================================================================
// Module  : captura_jogada
// Purpose : Synchronises and debounces 8 raw buttons. It accepts one clean
//           single-button press per physical press and emits the one-hot code
//           with a 1-cycle strobe. Optional inactivity timeout is enabled by
//           the JOGADA_TIMEOUT_EN macro.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module captura_jogada
  import jogo_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  wire logic       clock,
  input  wire logic       reset,
  captura_jogada_if.slave bus
);

  localparam int c_cnt_max = (DEBOUNCE_CYCLES > TIMEOUT_CYCLES) ? DEBOUNCE_CYCLES
                                                                : TIMEOUT_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [JOGADA_W-1:0] w_s;
  estado_t             r_estado;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [JOGADA_W-1:0] r_cand;
  logic [JOGADA_W-1:0] r_jogada;
  logic                r_valida;
  logic                r_tem;

  sincronizador_2ff #(.WIDTH(JOGADA_W)) u_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (bus.botoes),
    .o_q   (w_s)
  );

  // Press/release debounce FSM. Outputs are registered alongside the state.
  // The counter cannot exceed the debounce limit because it only advances below it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= ESPERA;
      r_cnt    <= '0;
      r_cand   <= '0;
      r_jogada <= '0;
      r_valida <= 1'b0;
      r_tem    <= 1'b0;
    end else begin
      r_valida <= 1'b0;
      r_tem    <= 1'b0;
      unique case (r_estado)
        ESPERA: begin
          if (is_onehot(w_s)) begin
            r_cand   <= w_s;
            r_cnt    <= '0;
            r_estado <= FILTRA;
          end
        end
        FILTRA: begin
          if (w_s != r_cand) begin
            r_estado <= ESPERA;
          end else if (r_cnt == c_deb_last) begin
            r_estado <= EMITE;
            r_jogada <= r_cand;
            r_valida <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        EMITE: begin
          r_estado <= SEGURA;
          r_tem    <= 1'b1;
        end
        SEGURA: begin
          // Extra buttons while held are ignored; only a full release matters
          if (w_s == '0) begin
            r_estado <= SOLTA;
            r_cnt    <= '0;
          end else begin
            r_tem <= 1'b1;
          end
        end
        SOLTA: begin
          if (w_s != '0) begin
            r_estado <= SEGURA;
            r_tem    <= 1'b1;
          end else if (r_cnt == c_deb_last) begin
            r_estado <= ESPERA;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: r_estado <= ESPERA;
      endcase
    end
  end

  assign bus.jogada        = r_jogada;
  assign bus.jogada_valida = r_valida;
  assign bus.tem_jogada    = r_tem;

`ifdef JOGADA_TIMEOUT_EN
  localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_idle;
  logic               r_timeout;

  // Idle counter runs only while waiting for a press. Timeout is sticky until iniciar.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (bus.iniciar) begin
        r_timeout <= 1'b0;
      end
      if (bus.iniciar || r_valida) begin
        r_idle <= '0;
      end else if (r_estado == ESPERA) begin
        if (r_idle == c_to_last) begin
          r_timeout <= 1'b1;
        end
        if (r_idle != '1) begin
          r_idle <= r_idle + c_cnt_w'(1);
        end
      end
    end
  end

  assign bus.timeout = r_timeout;
`else
  logic w_unused_iniciar;
  assign w_unused_iniciar = bus.iniciar;
  assign bus.timeout      = 1'b0;
`endif

endmodule

`default_nettype wire
